// File: rtl/lsu_dmem_master.sv
// ---------------------------------------------------------------------------
// lsu_dmem_master
//
// Load/store initiator that sits between the datapath and a word-addressed
// Data_Memory. It accepts one request at a time, performs sub-word loads by
// extraction with sign or zero extension, and performs sub-word stores as a
// read-modify-write because the memory only writes whole words. Each request
// ends in a single-cycle response pulse.
//
// Ports
//   clk, rst_n          clock and synchronous active-low reset
//   req_valid/ready     request handshake (ready only while idle)
//   req_we              1 = store, 0 = load
//   req_funct3          000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_addr/wdata      byte address and store data
//   resp_valid          one-cycle response pulse (no backpressure)
//   resp_rdata/err      extended load data (0 for stores/errors), error flag
//   mem_addr            word-aligned address to Data_Memory
//   mem_wdata/MemRW     write word and read/write select (0 = write)
//   mem_rdata           combinational read data from Data_Memory
// ---------------------------------------------------------------------------
module lsu_dmem_master #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_MemRW,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RMW_RD,
        WR,
        RESP
    } state_t;

    state_t      stateReg;
    logic [31:0] addrReg;
    logic [2:0]  funct3Reg;
    logic [15:0] wdataReg;      // only the low half is ever merged into memory
    logic [31:0] wordReg;       // word written in WR (SW data or merged word)
    logic [31:0] respRdataReg;
    logic        respErrReg;

    logic        reqErr;
    logic [31:0] loadShifted;
    logic [31:0] loadData;
    logic [31:0] mergeWord;

    // Request decode, evaluated on the live request inputs while idle.
    always_comb begin
        reqErr = 1'b0;
        case (req_funct3)
            3'b000:  reqErr = 1'b0;
            3'b001:  reqErr = req_addr[0];
            3'b010:  reqErr = |req_addr[1:0];
            3'b100:  reqErr = req_we;
            3'b101:  reqErr = req_we | req_addr[0];
            default: reqErr = 1'b1;
        endcase
        if (req_addr >= 32'(MEM_BYTES)) begin
            reqErr = 1'b1;
        end
    end

    // Load extraction: shift the addressed byte down to lane 0, then extend.
    // Halfwords are aligned, so the same byte shift places them correctly.
    assign loadShifted = mem_rdata >> {addrReg[1:0], 3'b000};

    always_comb begin
        loadData = mem_rdata;
        case (funct3Reg)
            3'b000:  loadData = {{24{loadShifted[7]}}, loadShifted[7:0]};
            3'b001:  loadData = {{16{loadShifted[15]}}, loadShifted[15:0]};
            3'b100:  loadData = {24'd0, loadShifted[7:0]};
            3'b101:  loadData = {16'd0, loadShifted[15:0]};
            default: loadData = mem_rdata;
        endcase
    end

    // Store merge, one byte lane at a time. funct3Reg[0] distinguishes
    // SH (lane pair chosen by addr[1]) from SB (single lane chosen by addr[1:0]).
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : gLane
            localparam int          HALF = gi / 2;
            localparam int          SUB  = gi % 2;
            localparam logic [1:0]  LANE = 2'(gi);
            logic       laneHit;
            logic [7:0] storeByte;

            assign laneHit   = funct3Reg[0] ? (addrReg[1] == HALF[0])
                                            : (addrReg[1:0] == LANE);
            assign storeByte = funct3Reg[0] ? wdataReg[8*SUB +: 8]
                                            : wdataReg[7:0];
            assign mergeWord[8*gi +: 8] = laneHit ? storeByte
                                                  : mem_rdata[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateReg     <= IDLE;
            addrReg      <= 32'd0;
            funct3Reg    <= 3'd0;
            wdataReg     <= 16'd0;
            wordReg      <= 32'd0;
            respRdataReg <= 32'd0;
            respErrReg   <= 1'b0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (req_valid) begin
                        addrReg   <= req_addr;
                        funct3Reg <= req_funct3;
                        wdataReg  <= req_wdata[15:0];
                        wordReg   <= req_wdata;
                        if (reqErr) begin
                            respErrReg   <= 1'b1;
                            respRdataReg <= 32'd0;
                            stateReg     <= RESP;
                        end else if (!req_we) begin
                            stateReg <= RD;
                        end else if (req_funct3 == 3'b010) begin
                            stateReg <= WR;
                        end else begin
                            stateReg <= RMW_RD;
                        end
                    end
                end
                RD: begin
                    respRdataReg <= loadData;
                    respErrReg   <= 1'b0;
                    stateReg     <= RESP;
                end
                RMW_RD: begin
                    wordReg  <= mergeWord;
                    stateReg <= WR;
                end
                WR: begin
                    respRdataReg <= 32'd0;
                    respErrReg   <= 1'b0;
                    stateReg     <= RESP;
                end
                RESP: begin
                    // Clear so the response fields read 0 outside the pulse.
                    respRdataReg <= 32'd0;
                    respErrReg   <= 1'b0;
                    stateReg     <= IDLE;
                end
                default: stateReg <= IDLE;
            endcase
        end
    end

    // All outputs decode directly from registered state, so reset forces
    // MemRW high in the same edge that abandons a pending write.
    assign req_ready  = (stateReg == IDLE);
    assign resp_valid = (stateReg == RESP);
    assign resp_rdata = respRdataReg;
    assign resp_err   = respErrReg;
    assign mem_addr   = {addrReg[31:2], 2'b00};
    assign mem_MemRW  = (stateReg != WR);
    assign mem_wdata  = (stateReg == WR) ? wordReg : 32'd0;

endmodule

// File: tb/tb_lsu_dmem_master.sv
// ---------------------------------------------------------------------------
// tb_lsu_dmem_master
//
// Directed bench for lsu_dmem_master with a behavioural Data_Memory model.
// The driver pushes the expected response of each request into a queue; a
// monitor on the falling edge pops and compares whenever resp_valid is seen,
// including response latency and the number of write cycles issued.
// ---------------------------------------------------------------------------
module tb_lsu_dmem_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_MemRW;
    logic [31:0] mem_rdata;

    lsu_dmem_master #(.MEM_BYTES(1024)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_MemRW  (mem_MemRW),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Data_Memory model: combinational read, write on the edge when MemRW = 0.
    logic [31:0] mem [256];
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (!mem_MemRW) mem[mem_addr[9:2]] <= mem_wdata;
    end

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int vectors     = 0;
    int miscompares = 0;
    int writeCount  = 0;
    int respSeen    = 0;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          writes;
        int          acceptCycle;
        int          writesBefore;
    } exp_t;

    exp_t expQ[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: counts write cycles and scores every response pulse.
    always @(negedge clk) begin
        if (mem_MemRW === 1'b0) writeCount++;
        if (rst_n && resp_valid) begin
            if (expQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
            end else begin
                exp_t e;
                e = expQ.pop_front();
                check({e.name, "_rdata"}, resp_rdata, e.rdata);
                check({e.name, "_err"}, 32'(resp_err), 32'(e.err));
                check({e.name, "_latency"}, 32'(cycle - e.acceptCycle + 1), 32'(e.lat));
                check({e.name, "_writes"}, 32'(writeCount - e.writesBefore), 32'(e.writes));
                check({e.name, "_addr_align"}, 32'(mem_addr[1:0]), 32'd0);
                $display("vec %-10s rdata=0x%08h err=%0d lat=%0d writes=%0d",
                         e.name, resp_rdata, resp_err, cycle - e.acceptCycle + 1,
                         writeCount - e.writesBefore);
            end
            respSeen++;
        end
    end

    task automatic issue(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] expRdata, input logic expErr,
                         input int expLat, input int expWrites);
        int waitCnt;
        int seenBefore;
        exp_t e;
        @(negedge clk);
        waitCnt = 0;
        while (req_ready !== 1'b1 && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        if (req_ready !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_ready_timeout: got req_ready=%b expected 1", name, req_ready);
            return;
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        e.name         = name;
        e.rdata        = expRdata;
        e.err          = expErr;
        e.lat          = expLat;
        e.writes       = expWrites;
        e.acceptCycle  = cycle + 1;
        e.writesBefore = writeCount;
        seenBefore     = respSeen;
        expQ.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'hFFFF_FFFF;
        waitCnt = 0;
        while (respSeen == seenBefore && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        if (respSeen == seenBefore) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_resp_timeout: got no resp_valid expected a response", name);
            void'(expQ.pop_front());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int wb;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[0] = 32'hABCDEF01;
        mem[1] = 32'h98765432;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        repeat (3) @(negedge clk);

        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_MemRW", 32'(mem_MemRW), 32'd1);
        rst_n = 1'b1;

        // Loads: name, we, funct3, addr, wdata, rdata, err, latency, writes
        issue("LW_0",   1'b0, 3'b010, 32'h0, 32'h0, 32'hABCDEF01, 1'b0, 2, 0);
        issue("LB_3",   1'b0, 3'b000, 32'h3, 32'h0, 32'hFFFFFFAB, 1'b0, 2, 0);
        issue("LBU_3",  1'b0, 3'b100, 32'h3, 32'h0, 32'h000000AB, 1'b0, 2, 0);
        issue("LH_2",   1'b0, 3'b001, 32'h2, 32'h0, 32'hFFFFABCD, 1'b0, 2, 0);
        issue("LHU_6",  1'b0, 3'b101, 32'h6, 32'h0, 32'h00009876, 1'b0, 2, 0);
        issue("LB_0",   1'b0, 3'b000, 32'h0, 32'h0, 32'h00000001, 1'b0, 2, 0);
        issue("LH_0",   1'b0, 3'b001, 32'h0, 32'h0, 32'hFFFFEF01, 1'b0, 2, 0);
        issue("LW_4",   1'b0, 3'b010, 32'h4, 32'h0, 32'h98765432, 1'b0, 2, 0);

        // SB with reset sampled at the edge that ends the RMW_RD cycle.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h00000077;
        wb         = writeCount;
        @(negedge clk);
        req_valid = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        check("rstmid_resp_valid", 32'(resp_valid), 32'd0);
        check("rstmid_req_ready", 32'(req_ready), 32'd1);
        check("rstmid_MemRW", 32'(mem_MemRW), 32'd1);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rstmid_writes", 32'(writeCount - wb), 32'd0);
        $display("vec rst_mid   writes=%0d", writeCount - wb);
        issue("LW_0_rst", 1'b0, 3'b010, 32'h0, 32'h0, 32'hABCDEF01, 1'b0, 2, 0);

        // Stores.
        issue("SB_1",   1'b1, 3'b000, 32'h1, 32'h12345655, 32'h0, 1'b0, 3, 1);
        issue("LW_0b",  1'b0, 3'b010, 32'h0, 32'h0, 32'hABCD5501, 1'b0, 2, 0);
        issue("SH_4",   1'b1, 3'b001, 32'h4, 32'h0000BEEF, 32'h0, 1'b0, 3, 1);
        issue("LW_4b",  1'b0, 3'b010, 32'h4, 32'h0, 32'h9876BEEF, 1'b0, 2, 0);
        issue("SH_6",   1'b1, 3'b001, 32'h6, 32'h00001234, 32'h0, 1'b0, 3, 1);
        issue("LW_4c",  1'b0, 3'b010, 32'h4, 32'h0, 32'h1234BEEF, 1'b0, 2, 0);
        issue("SW_8",   1'b1, 3'b010, 32'h8, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1);
        issue("LW_8",   1'b0, 3'b010, 32'h8, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0);

        // Errors: no access, response one edge after acceptance.
        issue("E_LW_2",   1'b0, 3'b010, 32'h2,   32'h0, 32'h0, 1'b1, 1, 0);
        issue("E_SH_1",   1'b1, 3'b001, 32'h1,   32'hFFFF, 32'h0, 1'b1, 1, 0);
        issue("E_LW_400", 1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 1'b1, 1, 0);
        issue("E_F3_011", 1'b0, 3'b011, 32'h0,   32'h0, 32'h0, 1'b1, 1, 0);
        issue("E_SBU",    1'b1, 3'b100, 32'h0,   32'hFF, 32'h0, 1'b1, 1, 0);
        issue("E_SW_3FF", 1'b1, 3'b010, 32'h3FF, 32'h0, 32'h0, 1'b1, 1, 0);

        // Highest legal addresses.
        issue("LW_3FC",  1'b0, 3'b010, 32'h3FC, 32'h0, 32'h00000000, 1'b0, 2, 0);
        issue("SB_3FF",  1'b1, 3'b000, 32'h3FF, 32'h000000C3, 32'h0, 1'b0, 3, 1);
        issue("LB_3FF",  1'b0, 3'b000, 32'h3FF, 32'h0, 32'hFFFFFFC3, 1'b0, 2, 0);
        issue("LW_3FCb", 1'b0, 3'b010, 32'h3FC, 32'h0, 32'hC3000000, 1'b0, 2, 0);

        // Memory untouched by the error cases.
        issue("LW_0c",  1'b0, 3'b010, 32'h0, 32'h0, 32'hABCD5501, 1'b0, 2, 0);

        repeat (4) @(negedge clk);
        check("queue_drained", 32'(expQ.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
